// File: rtl/seq_squarer_pkg.sv
// Shared definitions for the sequential shift-and-add squarer:
// state encoding and counter sizing.
package seq_squarer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bits needed to hold the value w itself (the initial iteration count).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_squarer_prims.sv
// Generic datapath primitives: an N-bit adder and an N-bit 2:1 mux.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  // Modulo-2^N sum; callers that need the carry widen the operands.
  assign sum = a + b;

endmodule

module mux2_n #(
  parameter int N = 8
) (
  input  logic         sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/seq_squarer_step.sv
// One combinational shift-and-add iteration: conditional accumulate of the
// multiplicand and a left shift of the multiplicand.
module squarer_step #(
  parameter int W = 22
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] mcand,
  input  logic         mplier_lsb,
  output logic [W-1:0] acc_next,
  output logic [W-1:0] mcand_next
);

  logic [W-1:0] acc_sum;

  // The carry out cannot occur for in-range operands, so a W-bit sum is exact.
  adder_n #(.N(W)) u_add (
    .a   (acc),
    .b   (mcand),
    .sum (acc_sum)
  );

  mux2_n #(.N(W)) u_sel (
    .sel (mplier_lsb),
    .a   (acc),
    .b   (acc_sum),
    .y   (acc_next)
  );

  assign mcand_next = {mcand[W-2:0], 1'b0};

endmodule

// File: rtl/seq_squarer.sv
// Sequential shift-and-add squarer: accepts x, returns the exact 2*WIDTH-bit
// x*x after WIDTH cycles, with valid/ready handshakes on both sides.
module seq_squarer
  import seq_squarer_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  state_t          state;
  state_t          next_state;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   mcand;
  logic [RW-1:0]   acc_next;
  logic [RW-1:0]   mcand_next;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;

  squarer_step #(.W(RW)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier_lsb (mplier[0]),
    .acc_next   (acc_next),
    .mcand_next (mcand_next)
  );

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (in_valid) next_state = RUN;
        else          next_state = IDLE;
      end
      RUN: begin
        if (cnt == CW'(1)) next_state = DONE;
        else               next_state = RUN;
      end
      DONE: begin
        if (out_ready) next_state = IDLE;
        else           next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operand capture and iteration; acc is left intact after DONE so the
  // last result remains visible in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, x};
            mplier <= x;
            cnt    <= CW'(WIDTH);
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = acc;

endmodule

// File: tb/tb_seq_squarer.sv
// Self-checking bench for seq_squarer: directed cases plus random operands,
// compared against plain integer multiplication and cycle-count expectations.
module tb_seq_squarer;

  localparam int WIDTH = 11;
  localparam int RW    = 2 * WIDTH;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     result;

  int n_checks;
  int n_fail;

  seq_squarer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] sq(input int unsigned v);
    longint unsigned p;
    p = longint'(v) * longint'(v);
    return p[RW-1:0];
  endfunction

  // Full transaction: accept xv, measure latency, hold the result for
  // hold cycles with out_ready low, then complete the transfer.
  // If glitch is set, an in_valid pulse with x=9 is injected during RUN.
  task automatic run_op(input string tag, input int unsigned xv, input int hold, input bit glitch);
    int cyc;
    logic [RW-1:0] expv;
    expv = sq(xv);
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    x = WIDTH'(xv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      if (glitch && cyc == 3) begin
        in_valid = 1'b1;
        x = WIDTH'(9);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(WIDTH));
    check({tag, "_result"}, 64'(result), 64'(expv));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_inready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_result"}, 64'(result), 64'(expv));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_xfer_inready"}, 64'(in_ready), 64'd1);
    check({tag, "_xfer_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_result"}, 64'(result), 64'(expv));
  endtask

  initial begin
    logic [RW-1:0] exp_q[$];
    int            last_acc;
    bit            acc_now;
    int            n_acc;
    int            cyc;

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    #1;
    check("rst_inready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_op("zero", 0, 0, 1'b0);
    run_op("x1448", 1448, 0, 1'b0);
    run_op("allones", 2047, 0, 1'b0);
    run_op("x5_hold", 5, 6, 1'b0);
    run_op("ignore9", 3, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_op("rand", $urandom_range(2047, 0), $urandom_range(3, 0), 1'b0);
    end

    // Back-to-back accepts with out_ready tied high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = WIDTH'($urandom_range(2047, 0));
    last_acc  = -1;
    n_acc     = 0;
    for (int c = 0; c < 60; c++) begin
      acc_now = in_ready && in_valid;
      if (acc_now) begin
        exp_q.push_back(sq(int'(x)));
        if (last_acc >= 0) check("b2b_spacing", 64'(c - last_acc), 64'(WIDTH + 2));
        last_acc = c;
        n_acc++;
      end
      if (out_valid) begin
        if (exp_q.size() > 0) check("b2b_result", 64'(result), 64'(exp_q.pop_front()));
        else                  check("b2b_queue", 64'(exp_q.size()), 64'd1);
      end
      tick();
      if (acc_now) x = WIDTH'($urandom_range(2047, 0));
    end
    in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (out_valid) check("b2b_drain", 64'(result), 64'(exp_q.pop_front()));
      tick();
      cyc++;
    end
    check("b2b_drained", 64'(exp_q.size()), 64'd0);
    check("b2b_accepts", 64'(n_acc >= 4), 64'd1);
    out_ready = 1'b0;
    tick();

    // Reset in the middle of a computation.
    x = WIDTH'(1000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst_inready", 64'(in_ready), 64'd1);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    run_op("after_rst", 7, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
